// File: rtl/ray_fetch_unpacker_pkg.sv
// Shared types and constants for the ray fetch path: block geometry,
// counter/address widths and the fetch FSM state encoding.
package rt_pkg;

   localparam int WORD_W      = 32;
   localparam int BLOCK_BITS  = 2048;
   localparam int BLOCK_WORDS = 64;

   typedef logic [29:0] ray_count_t;
   typedef logic [31:0] sdr_addr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_STREAM,
      ST_DONE
   } fetch_state_t;

   function automatic ray_count_t min_count(input ray_count_t a, input ray_count_t b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/ray_fetch_unpacker_buffer.sv
// Holds one SDRAM read block and presents the ray record selected by slot.
module ray_block_buffer
   import rt_pkg::*;
#(
   parameter  int WORDS_PER_RAY = 8,
   localparam int RPB           = BLOCK_WORDS / WORDS_PER_RAY,
   localparam int RAY_W         = WORD_W * WORDS_PER_RAY,
   localparam int SLOT_W        = (RPB > 1) ? $clog2(RPB) : 1
)
(
   input  logic                  sdr_clk,
   input  logic                  sdr_reset,
   input  logic                  i_load,
   input  logic [BLOCK_BITS-1:0] i_data,
   input  logic [SLOT_W-1:0]     i_slot,
   output logic [RAY_W-1:0]      o_ray
);

   logic [BLOCK_BITS-1:0] r_block;
   logic [RAY_W-1:0]      w_slots [RPB];

   always_ff @(posedge sdr_clk or posedge sdr_reset) begin
      if (sdr_reset) begin
         r_block <= '0;
      end else if (i_load) begin
         r_block <= i_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RPB; gi++) begin : g_slot
         assign w_slots[gi] = r_block[gi*RAY_W +: RAY_W];
      end
   endgenerate

   assign o_ray = w_slots[i_slot];

endmodule

// File: rtl/ray_fetch_unpacker.sv
// Reads packed ray blocks from SDRAM and streams one ray record per
// valid/ready handshake, requesting the next block once the current one drains.
module ray_fetch_unpacker
   import rt_pkg::*;
#(
   parameter int WORDS_PER_RAY = 8,
   parameter int ADDR_STEP     = 256
)
(
   input  logic                        sdr_clk,
   input  logic                        sdr_reset,
   input  logic                        start,
   input  logic [31:0]                 base_addr,
   input  logic [29:0]                 num_rays,
   output logic                        sdr_readstart,
   output logic [31:0]                 sdr_baseaddr,
   output logic [29:0]                 sdr_nelems,
   input  logic                        sdr_readend,
   input  logic [2047:0]               sdr_readdata,
   output logic                        ray_valid,
   input  logic                        ray_ready,
   output logic [32*WORDS_PER_RAY-1:0] ray_data,
   output logic [29:0]                 ray_index,
   output logic                        ray_last,
   output logic                        busy,
   output logic                        done
);

   localparam int RPB    = BLOCK_WORDS / WORDS_PER_RAY;
   localparam int CNT_W  = $clog2(RPB + 1);
   localparam int SLOT_W = (RPB > 1) ? $clog2(RPB) : 1;

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   ray_count_t   r_remaining;
   ray_count_t   r_ray_index;
   sdr_addr_t    r_addr;
   logic [CNT_W-1:0] r_slot;
   logic [CNT_W-1:0] r_blk_rays;

   ray_count_t   w_blk_min;
   ray_count_t   w_nelems;
   logic         w_blk_end;
   logic         w_load;

   assign w_blk_min = min_count(r_remaining, ray_count_t'(RPB));
   assign w_nelems  = ray_count_t'(w_blk_min * ray_count_t'(WORDS_PER_RAY));
   assign w_blk_end = ((r_slot + CNT_W'(1)) == r_blk_rays);
   assign w_load    = (r_state == ST_WAIT) && sdr_readend;

   always_ff @(posedge sdr_clk or posedge sdr_reset) begin
      if (sdr_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = (num_rays == '0) ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ:  w_state_next = ST_WAIT;
         ST_WAIT: begin
            if (sdr_readend) begin
               w_state_next = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (ray_ready && w_blk_end) begin
               w_state_next = (r_remaining == ray_count_t'(1)) ? ST_DONE : ST_REQ;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Block address only advances when another block is actually needed.
   always_ff @(posedge sdr_clk or posedge sdr_reset) begin
      if (sdr_reset) begin
         r_remaining <= '0;
         r_ray_index <= '0;
         r_addr      <= '0;
         r_slot      <= '0;
         r_blk_rays  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_ray_index <= '0;
                  if (num_rays != '0) begin
                     r_remaining <= num_rays;
                     r_addr      <= base_addr;
                  end
               end
            end
            ST_WAIT: begin
               if (sdr_readend) begin
                  r_slot     <= '0;
                  r_blk_rays <= CNT_W'(w_blk_min);
               end
            end
            ST_STREAM: begin
               if (ray_ready) begin
                  r_slot      <= r_slot + CNT_W'(1);
                  r_ray_index <= r_ray_index + ray_count_t'(1);
                  r_remaining <= r_remaining - ray_count_t'(1);
                  if (w_blk_end && (r_remaining != ray_count_t'(1))) begin
                     r_addr <= r_addr + sdr_addr_t'(ADDR_STEP);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   ray_block_buffer #(
      .WORDS_PER_RAY (WORDS_PER_RAY)
   ) u_block_buffer (
      .sdr_clk   (sdr_clk),
      .sdr_reset (sdr_reset),
      .i_load    (w_load),
      .i_data    (sdr_readdata),
      .i_slot    (r_slot[SLOT_W-1:0]),
      .o_ray     (ray_data)
   );

   assign sdr_readstart = (r_state == ST_REQ);
   assign sdr_baseaddr  = r_addr;
   assign sdr_nelems    = ((r_state == ST_REQ) || (r_state == ST_WAIT)) ? w_nelems : '0;
   assign ray_valid     = (r_state == ST_STREAM);
   assign ray_index     = r_ray_index;
   assign ray_last      = (r_state == ST_STREAM) && (r_remaining == ray_count_t'(1));
   assign busy          = (r_state != ST_IDLE);
   assign done          = (r_state == ST_DONE);

endmodule

// File: tb/tb_ray_fetch_unpacker.sv
// Directed bench for ray_fetch_unpacker: an SDRAM responder plus a
// cycle-level monitor checking reads, rays and done against a ray-index model.
module tb_ray_fetch_unpacker;

   logic          clk = 1'b0;
   logic          sdr_reset;
   logic          start;
   logic [31:0]   base_addr;
   logic [29:0]   num_rays;
   logic          sdr_readstart;
   logic [31:0]   sdr_baseaddr;
   logic [29:0]   sdr_nelems;
   logic          sdr_readend;
   logic [2047:0] sdr_readdata;
   logic          ray_valid;
   logic          ray_ready;
   logic [255:0]  ray_data;
   logic [29:0]   ray_index;
   logic          ray_last;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   ray_fetch_unpacker #(
      .WORDS_PER_RAY (8),
      .ADDR_STEP     (256)
   ) dut (
      .sdr_clk       (clk),
      .sdr_reset     (sdr_reset),
      .start         (start),
      .base_addr     (base_addr),
      .num_rays      (num_rays),
      .sdr_readstart (sdr_readstart),
      .sdr_baseaddr  (sdr_baseaddr),
      .sdr_nelems    (sdr_nelems),
      .sdr_readend   (sdr_readend),
      .sdr_readdata  (sdr_readdata),
      .ray_valid     (ray_valid),
      .ray_ready     (ray_ready),
      .ray_data      (ray_data),
      .ray_index     (ray_index),
      .ray_last      (ray_last),
      .busy          (busy),
      .done          (done)
   );

   int checks   = 0;
   int failures = 0;

   // Model of the current run
   logic [31:0] exp_base = 32'h0;
   int          exp_n      = 0;
   int          next_idx   = 0;
   int          reads_seen = 0;
   int          done_seen  = 0;
   bit          run_active = 1'b0;
   logic [31:0] log_addr [$];
   int          log_nel  [$];
   logic [31:0] log_w0   [$];

   // Responder controls
   int          resp_lat    = 2;
   bit          spurious_req = 1'b0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Word k of the block at byte address a
   function automatic logic [31:0] fw(input logic [31:0] a, input int k);
      return {a[23:0], 8'(k)};
   endfunction

   function automatic logic [2047:0] mk_block(input logic [31:0] a);
      logic [2047:0] b;
      for (int k = 0; k < 64; k++) b[k*32 +: 32] = fw(a, k);
      return b;
   endfunction

   function automatic logic [255:0] exp_ray(input int i);
      logic [255:0] r;
      logic [31:0]  ba;
      ba = exp_base + 32'(i / 8) * 32'd256;
      for (int j = 0; j < 8; j++) r[j*32 +: 32] = fw(ba, (i % 8) * 8 + j);
      return r;
   endfunction

   function automatic int exp_nelems(input int b);
      int rem;
      rem = exp_n - 8 * b;
      return ((rem < 8) ? rem : 8) * 8;
   endfunction

   // SDRAM responder: answers each read request after resp_lat cycles
   initial begin
      int          pend;
      logic [31:0] pend_addr;
      pend = -1;
      pend_addr = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         sdr_readend = 1'b0;
         if (pend == 0) begin
            sdr_readend  = 1'b1;
            sdr_readdata = mk_block(pend_addr);
            pend = -1;
         end else if (pend > 0) begin
            pend--;
         end else if (spurious_req) begin
            sdr_readend  = 1'b1;
            sdr_readdata = ~mk_block(32'h0);
            spurious_req = 1'b0;
         end
         if (sdr_readstart && !sdr_reset) begin
            pend_addr = sdr_baseaddr;
            pend      = resp_lat;
         end
      end
   end

   // Monitor: cycle-accurate checks against the model
   initial begin
      bit           p_start_new, p_zero_start, p_last_hs, p_blk_next, p_valid, p_ready, hs;
      logic [255:0] p_data;
      logic [29:0]  p_idx;
      p_start_new = 0; p_zero_start = 0; p_last_hs = 0; p_blk_next = 0;
      p_valid = 0; p_ready = 0; p_data = '0; p_idx = '0;
      forever begin
         @(negedge clk);
         if (sdr_reset) begin
            p_start_new = 0; p_zero_start = 0; p_last_hs = 0; p_blk_next = 0;
            p_valid = 0; p_ready = 0;
         end else begin
            chk("readstart_timing", 256'(sdr_readstart), 256'(p_start_new || p_blk_next));
            if (sdr_readstart && run_active) begin
               chk("read_needed", 256'(reads_seen * 8 < exp_n), 256'(1));
               chk("read_addr", 256'(sdr_baseaddr), 256'(exp_base + 32'(reads_seen) * 32'd256));
               chk("read_nelems", 256'(sdr_nelems), 256'(exp_nelems(reads_seen)));
               $display("read addr=%h nelems=%0d", sdr_baseaddr, sdr_nelems);
               log_addr.push_back(sdr_baseaddr);
               log_nel.push_back(int'(sdr_nelems));
               reads_seen++;
            end
            chk("done_timing", 256'(done), 256'(p_last_hs || p_zero_start));
            if (done) done_seen++;
            if (ray_valid) begin
               chk("ray_expected", 256'(run_active && next_idx < exp_n), 256'(1));
               chk("ray_index", 256'(ray_index), 256'(next_idx));
               chk("ray_data", ray_data, exp_ray(next_idx));
               chk("ray_last", 256'(ray_last), 256'(next_idx == exp_n - 1));
            end
            if (p_valid && !p_ready) begin
               chk("hold_valid", 256'(ray_valid), 256'(1));
               chk("hold_data", ray_data, p_data);
               chk("hold_index", 256'(ray_index), 256'(p_idx));
            end
            p_start_new  = start && !busy && (num_rays != 30'd0);
            p_zero_start = start && !busy && (num_rays == 30'd0);
            hs           = ray_valid && ray_ready;
            p_last_hs    = hs && (next_idx == exp_n - 1);
            p_blk_next   = hs && ((next_idx + 1) % 8 == 0) && (next_idx + 1 < exp_n);
            if (hs) begin
               $display("ray idx=%0d w0=%h last=%0d", ray_index, ray_data[31:0], ray_last);
               log_w0.push_back(ray_data[31:0]);
               next_idx++;
            end
            p_valid = ray_valid;
            p_ready = ray_ready;
            p_data  = ray_data;
            p_idx   = ray_index;
         end
      end
   end

   task automatic init_model(input logic [31:0] base, input int n, input int lat);
      exp_base   = base;
      exp_n      = n;
      next_idx   = 0;
      reads_seen = 0;
      resp_lat   = lat;
      log_addr.delete();
      log_nel.delete();
      log_w0.delete();
      run_active = 1'b1;
   endtask

   // mode 0: plain, 1: backpressure on ray 1, 2: ignored start/readend in STREAM
   task automatic do_run(input logic [31:0] base, input int n, input int lat, input int mode);
      int d0, cyc, bp;
      bit did_start, did_sp;
      init_model(base, n, lat);
      d0 = done_seen; cyc = 0; bp = 0; did_start = 0; did_sp = 0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; num_rays = 30'(n); ray_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0) begin
         chk("zero_done_c1", 256'(done), 256'(1));
         chk("zero_busy_c1", 256'(busy), 256'(1));
      end else begin
         chk("readstart_c1", 256'(sdr_readstart), 256'(1));
      end
      while (done_seen == d0 && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         ray_ready = 1'b1;
         start = 1'b0;
         if (mode == 1 && ray_valid && ray_index == 30'd1 && bp < 5) begin
            ray_ready = 1'b0;
            bp++;
         end
         if (mode == 2 && ray_valid && ray_index == 30'd3 && !did_start) begin
            start = 1'b1; num_rays = 30'd2; base_addr = 32'h5000;
            did_start = 1;
         end
         if (mode == 2 && ray_valid && ray_index == 30'd5 && !did_sp) begin
            spurious_req = 1'b1;
            did_sp = 1;
         end
      end
      start = 1'b0;
      chk("run_finished", 256'(done_seen != d0), 256'(1));
      chk("ray_count", 256'(next_idx), 256'(n));
      chk("read_count", 256'(reads_seen), 256'((n + 7) / 8));
      @(posedge clk); #1;
      chk("idle_after_done", 256'({busy, done}), 256'(0));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, 256'({sdr_readstart, ray_valid, ray_last, busy, done}), 256'(0));
      chk({tag, "_addr"}, 256'({sdr_baseaddr, sdr_nelems, ray_index}), 256'(0));
      chk({tag, "_data"}, ray_data, 256'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sdr_reset = 1'b1; start = 1'b0; base_addr = '0; num_rays = '0;
      sdr_readend = 1'b0; sdr_readdata = '0; ray_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      sdr_reset = 1'b0;
      @(posedge clk); #1;
      chk_all_zero("post_reset");

      // Single partial block
      do_run(32'h1000, 3, 2, 0);
      chk("p1_addr", 256'(log_addr[0]), 256'(32'h1000));
      chk("p1_nelems", 256'(log_nel[0]), 256'(24));
      chk("p1_ray1_w0", 256'(log_w0[1]), 256'(32'h0010_0008));
      chk("p1_ray2_w0", 256'(log_w0[2]), 256'(32'h0010_0010));

      // Two blocks
      do_run(32'h1000, 10, 3, 0);
      chk("p2_addr0", 256'(log_addr[0]), 256'(32'h1000));
      chk("p2_nel0", 256'(log_nel[0]), 256'(64));
      chk("p2_addr1", 256'(log_addr[1]), 256'(32'h1100));
      chk("p2_nel1", 256'(log_nel[1]), 256'(16));
      chk("p2_ray8_w0", 256'(log_w0[8]), 256'(32'h0011_0000));
      chk("p2_ray9_w0", 256'(log_w0[9]), 256'(32'h0011_0008));

      // Backpressure on ray 1
      do_run(32'h0000_2000, 4, 1, 1);

      // Zero rays
      do_run(32'h0000_4000, 0, 2, 0);

      // Reset while waiting for the read
      init_model(32'h3000, 5, 6);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 32'h3000; num_rays = 30'd5; ray_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("wait_busy", 256'(busy), 256'(1));
      sdr_reset = 1'b1;
      run_active = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      sdr_reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         chk_all_zero("after_reset");
      end
      do_run(32'h3000, 5, 2, 0);

      // Ignored start and spurious readend during STREAM
      do_run(32'h0000_6000, 12, 2, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ray_fetch_unpacker.md
# ray_fetch_unpacker

Fetches packed ray records from SDRAM through the `sdr_*` burst-read handshake and streams them one ray per handshake to the intersector. It sits between the HPS-driven `start_rt` trigger and the ray/triangle intersector, and replaces the ad-hoc read FSM and display loop in the system top level. Each 2048-bit read block is latched once, sliced into fixed-size ray records, and emitted over a valid/ready interface. The next block is requested once the current block is exhausted.

## Interface
- `WORDS_PER_RAY`, default 8: 32-bit words per ray record. Must divide 64.
- `ADDR_STEP`, default 256: byte increment of `sdr_baseaddr` per block.
- `sdr_clk`  in  1  clock.
- `sdr_reset`  in  1  reset: sdr_reset, asynchronous, active-high; clock sdr_clk.
- `start`  in  1  one-cycle pulse; latches `base_addr` and `num_rays`.
- `base_addr`  in  32  byte address of ray 0.
- `num_rays`  in  30  total rays to stream.
- `sdr_readstart`  out  1  one-cycle read request pulse.
- `sdr_baseaddr`  out  32  block byte address.
- `sdr_nelems`  out  30  32-bit words in this block.
- `sdr_readend`  in  1  read complete; `sdr_readdata` valid this cycle.
- `sdr_readdata`  in  2048  block data, word 0 at LSB.
- `ray_valid`  out  1  ray presented.
- `ray_ready`  in  1  consumer accepts.
- `ray_data`  out  32*WORDS_PER_RAY  ray record.
- `ray_index`  out  30  global index of the presented ray.
- `ray_last`  out  1  presented ray is index `num_rays`-1.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last ray is accepted.

## Operation
- States: IDLE, REQ, WAIT, STREAM, DONE.
- IDLE:
  - On `start` with `num_rays` = 0, go to DONE.
  - On `start` otherwise, latch `remaining` = `num_rays` and `addr` = `base_addr`, then go to REQ.
- REQ:
  - `sdr_readstart` = 1 for exactly one cycle.
  - `sdr_nelems` = min(`remaining`, RPB) * `WORDS_PER_RAY`, where RPB = 64 / `WORDS_PER_RAY`.
  - Go to WAIT.
- WAIT:
  - Hold `sdr_baseaddr` and `sdr_nelems` stable.
  - On `sdr_readend`, capture `sdr_readdata` into the block register, set `slot` = 0, set `blk_rays` = min(`remaining`, RPB), and go to STREAM.
- STREAM:
  - `ray_data` = block[`slot`*32*`WORDS_PER_RAY` +: 32*`WORDS_PER_RAY`].
  - On `ray_valid && ray_ready`: `slot`++, `ray_index`++, `remaining`--.
  - On the handshake of the last ray in the block: if `remaining` after decrement = 0, go to DONE; otherwise `addr` += `ADDR_STEP` and go to REQ.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Valid/ready rules:
  - `ray_valid` is high only in STREAM.
  - Once raised, `ray_data`, `ray_index` and `ray_last` hold stable until the handshake.
  - `ray_valid` does not depend combinationally on `ray_ready`.
- Ignored events:
  - `start` outside IDLE.
  - `sdr_readend` outside WAIT.
- Reset values, any state, including mid-burst:
  - State = IDLE.
  - `sdr_readstart`, `ray_valid`, `ray_last`, `busy`, `done` = 0.
  - `sdr_baseaddr`, `sdr_nelems`, `ray_index`, `ray_data` = 0.
  - A `sdr_readend` arriving after reset is ignored.
- Counters are 30-bit. `addr` wraps modulo 2^32 with no error flag.

## Timing
- `start` at cycle 0 gives `sdr_readstart` in cycle 1 and WAIT from cycle 2.
- `sdr_readend` sampled at cycle N gives `ray_valid` from cycle N+1.
- In STREAM, throughput is one ray per cycle while `ray_ready` = 1.
- Between blocks, the cycle after the final handshake is REQ. `sdr_readstart` is asserted in that cycle, so the stall is 1 cycle plus the SDRAM latency.
- For `num_rays` = 0, `start` at cycle 0 gives `done` in cycle 1 with no read issued.
- `ray_last` is valid together with `ray_valid`.
- `done` is asserted one cycle after the last handshake.

## Structure
- Shared package `rt_pkg`:
  - `WORD_W` = 32, `BLOCK_BITS` = 2048, `BLOCK_WORDS` = 64.
  - State enum `fetch_state_t`.
  - `ray_count_t` (30-bit) and `sdr_addr_t` (32-bit) typedefs.
- Sub-module `ray_block_buffer`:
  - 2048-bit capture register with load enable.
  - Slot-indexed output mux parameterized by `WORDS_PER_RAY`.
  - FSM and counters stay in the parent.

## Test plan
- **Single partial block:** `num_rays`=3, `base_addr`=0x1000, `ray_ready`=1.
  - One read: `sdr_baseaddr`=0x1000, `sdr_nelems`=24.
  - Rays 0–2 carry words 0–7, 8–15 and 16–23.
  - `ray_last` is asserted on index 2; `done` follows one cycle later.
- **Two blocks:** `num_rays`=10.
  - First read: 0x1000/64, 8 rays.
  - Second read: 0x1100/16, 2 rays.
  - `ray_index` runs 0–9 with no gaps.
- **Backpressure:** hold `ray_ready`=0 for 5 cycles on ray 1.
  - `ray_data` and `ray_index` stay stable throughout.
  - No ray is skipped or duplicated.
- **Zero rays:** `num_rays`=0.
  - `done` in cycle 1 and `busy` high for that one cycle.
  - `sdr_readstart` never asserts.
- **Reset in WAIT:** assert `sdr_reset` in WAIT, then deliver `sdr_readend` after release.
  - All outputs are 0 and the FSM stays in IDLE.
  - A following `start` completes normally.
- **Ignored events:**
  - A `start` pulse in STREAM does not change `remaining`.
  - A spurious `sdr_readend` in STREAM does not reload the block register.
